// File: rtl/exp2_pkg.sv
// -----------------------------------------------------------------------------
// exp2_pkg
// Shared definitions for the base-2 antilogarithm datapath:
//   - FSM state encoding
//   - default fraction / integer exponent widths
//   - C[k] = 2^(2^-k) as 17-bit Q1.16, rounded to nearest, for k = 1..16
// -----------------------------------------------------------------------------
package exp2_pkg;

   localparam int FRAC_W = 16;
   localparam int INT_W  = 4;
   localparam int ACC_W  = FRAC_W + 1;   // Q1.16 accumulator
   localparam int RES_W  = 32;           // Q16.16 result

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_MUL,
      S_SHIFT,
      S_DONE
   } state_e;

   // C[k] multiplies the accumulator when fraction bit (16-k) is set.
   localparam logic [ACC_W-1:0] C [1:16] = '{
      17'h16A0A, 17'h13070, 17'h1172C, 17'h10B56,
      17'h1059B, 17'h102CA, 17'h10164, 17'h100B2,
      17'h10059, 17'h1002C, 17'h10016, 17'h1000B,
      17'h10006, 17'h10003, 17'h10001, 17'h10001
   };

endpackage

// File: rtl/antilog_base2_16bit_if.sv
// -----------------------------------------------------------------------------
// antilog_base2_16bit_if
// Request/response bundle of the antilog engine.
//   start_i      request pulse (sampled only while the engine is idle)
//   ynguyen_i    integer part n of the exponent
//   ythapphan_i  fraction f, bit 15 = 2^-1 ... bit 0 = 2^-16
//   busy_o       engine is not idle
//   done_o       one-cycle pulse, result_o just became valid
//   result_o     2^(n+f), unsigned Q16.16, held until the next completion
// Modports: master = requester, slave = engine.
// -----------------------------------------------------------------------------
interface antilog_base2_16bit_if #(
   parameter int FRAC_W = exp2_pkg::FRAC_W,
   parameter int INT_W  = exp2_pkg::INT_W
);
   import exp2_pkg::*;

   logic                start_i;
   logic [INT_W-1:0]    ynguyen_i;
   logic [FRAC_W-1:0]   ythapphan_i;
   logic                busy_o;
   logic                done_o;
   logic [RES_W-1:0]    result_o;

   modport master (
      output start_i, ynguyen_i, ythapphan_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, ynguyen_i, ythapphan_i,
      output busy_o, done_o, result_o
   );

endinterface

// File: rtl/shift_add_mul_17.sv
// -----------------------------------------------------------------------------
// shift_add_mul_17
// 17x17 unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk_i      clock
//   rst_i      asynchronous active-low reset, clears all state
//   start_i    launch a multiply with a_i * b_i (ignored while running)
//   a_i, b_i   17-bit operands
//   done_o     high for one cycle when product_o is valid, exactly 17 cycles
//              after the launching edge's following cycle count
//   product_o  34-bit product
// Bit 0 of b_i is consumed on the launching edge, bits 1..16 on the next 16
// edges, so done_o is high in the 17th cycle after launch.
// -----------------------------------------------------------------------------
module shift_add_mul_17 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [16:0] a_i,
   input  logic [16:0] b_i,
   output logic        done_o,
   output logic [33:0] product_o
);

   logic [33:0] prod_q, prod_d;
   logic [33:0] mcand_q, mcand_d;
   logic [16:0] mplier_q, mplier_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        run_q, run_d;

   assign done_o    = run_q && (cnt_q == 5'd17);
   assign product_o = prod_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i && !run_q) begin
         prod_d   = b_i[0] ? {17'b0, a_i} : 34'b0;
         mcand_d  = {16'b0, a_i, 1'b0};
         mplier_d = b_i >> 1;
         cnt_d    = 5'd1;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (cnt_q == 5'd17) begin
            run_d = 1'b0;
         end else begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: non-blocking assignments so every register takes its new value at the same edge.
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/antilog_base2_16bit.sv
// -----------------------------------------------------------------------------
// antilog_base2_16bit
// Iterative 2^(n+f): the fraction is expanded as a product of C[k] = 2^(2^-k)
// over its set bits (MSB first), then the integer part is a left shift.
//   clk_i   clock
//   rst_i   asynchronous active-low reset
//   bus_if  request/response bundle (slave side), see antilog_base2_16bit_if
// Latency from the accepting edge to done_o: 18 + 17 * popcount(f) cycles.
// -----------------------------------------------------------------------------
module antilog_base2_16bit #(
   parameter int FRAC_W = exp2_pkg::FRAC_W,
   parameter int INT_W  = exp2_pkg::INT_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   antilog_base2_16bit_if.slave  bus_if
);
   import exp2_pkg::*;

   localparam int AW = FRAC_W + 1;
   localparam int KW = $clog2(FRAC_W + 2);
   localparam logic [KW-1:0] K_LAST  = KW'(FRAC_W + 1);
   localparam logic [AW-1:0] ACC_ONE = AW'(1) << FRAC_W;

   state_e              state_q, state_d;
   logic [INT_W-1:0]    n_q, n_d;
   logic [FRAC_W-1:0]   f_q, f_d;     // shifted left as k advances; MSB is bit (16-k)
   logic [AW-1:0]       acc_q, acc_d;
   logic [KW-1:0]       k_q, k_d;
   logic [RES_W-1:0]    result_q, result_d;

   logic                mul_start;
   logic                mul_done;
   logic [2*AW-1:0]     mul_prod;
   logic                unused_prod_bits;

   shift_add_mul_17 u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (mul_start),
      .a_i       (acc_q),
      .b_i       (C[k_q]),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // acc * C stays below 2.0, so the top bit and the truncated LSBs are dropped.
   assign unused_prod_bits = ^{mul_prod[2*AW-1], mul_prod[FRAC_W-1:0]};

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      f_d       = f_q;
      acc_d     = acc_q;
      k_d       = k_q;
      result_d  = result_q;
      mul_start = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus_if.start_i) begin
               n_d     = bus_if.ynguyen_i;
               f_d     = bus_if.ythapphan_i;
               acc_d   = ACC_ONE;
               k_d     = KW'(1);
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (k_q == K_LAST) begin
               state_d = S_SHIFT;
            end else if (f_q[FRAC_W-1]) begin
               mul_start = 1'b1;
               state_d   = S_MUL;
            end else begin
               k_d = k_q + KW'(1);
               f_d = f_q << 1;
            end
         end
         S_MUL: begin
            if (mul_done) begin
               acc_d   = mul_prod[2*FRAC_W:FRAC_W];
               k_d     = k_q + KW'(1);
               f_d     = f_q << 1;
               state_d = S_SCAN;
            end
         end
         S_SHIFT: begin
            result_d = {{(RES_W-AW){1'b0}}, acc_q} << n_q;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         f_q      <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         f_q      <= f_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         result_q <= result_d;
      end
   end

   assign bus_if.busy_o   = (state_q != S_IDLE);
   assign bus_if.done_o   = (state_q == S_DONE);
   assign bus_if.result_o = result_q;

endmodule

// File: tb/tb_antilog_base2_16bit.sv
// -----------------------------------------------------------------------------
// tb_antilog_base2_16bit
// Directed vectors for the antilog engine. The stimulus side pushes the
// expected result and latency into a scoreboard queue; a negedge monitor pops
// and compares whenever done_o is seen. A bit-exact reference (truncating
// product chain with constants derived from 2^(2^-k)) and a real-valued
// 2^(n+f) bound are both applied.
// -----------------------------------------------------------------------------
module tb_antilog_base2_16bit;

   typedef struct {
      logic [31:0] res;
      int unsigned accept_cyc;
      int unsigned lat;
      logic [3:0]  n;
      logic [15:0] f;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          done_seen = 0;
   exp_t        sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   antilog_base2_16bit_if bus ();

   antilog_base2_16bit dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .bus_if (bus)
   );

   task automatic check(input string name, input bit ok,
                        input longint unsigned act, input longint unsigned req);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // 2^(2^-k) in Q1.16, rounded to nearest.
   function automatic logic [16:0] c_const(input int k);
      real r;
      r = 2.0 ** (1.0 / (2.0 ** k));
      return 17'($rtoi(r * 65536.0 + 0.5));
   endfunction

   // Bit-exact reference: truncating Q1.16 product chain, then shift by n.
   function automatic logic [31:0] model_exp(input logic [3:0] n, input logic [15:0] f);
      logic [16:0] acc;
      logic [33:0] p;
      acc = 17'h10000;
      for (int k = 1; k <= 16; k++) begin
         if (f[16-k]) begin
            p   = {17'b0, acc} * {17'b0, c_const(k)};
            acc = p[32:16];
         end
      end
      return {15'b0, acc} << n;
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      exp_t        e;
      int unsigned lat;
      real         want_r, tol_r, err_r;
      if (rst_n && bus.done_o) begin
         done_seen = done_seen + 1;
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1'b0, bus.result_o, 0);
         end else begin
            e   = sb_q.pop_front();
            lat = cyc - e.accept_cyc;
            check({e.tag, "_result"}, bus.result_o == e.res, bus.result_o, e.res);
            check({e.tag, "_latency"}, lat == e.lat, lat, e.lat);
            check({e.tag, "_busy_at_done"}, bus.busy_o == 1'b1, bus.busy_o, 1);
            want_r = (2.0 ** (real'(e.n) + real'(e.f) / 65536.0)) * 65536.0;
            tol_r  = 16.0 * (2.0 ** real'(e.n));
            err_r  = real'(bus.result_o) - want_r;
            if (err_r < 0.0) err_r = -err_r;
            check({e.tag, "_within_16lsb"}, err_r <= tol_r, bus.result_o, longint'(want_r));
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   // Called at a negedge; returns just after the accepting posedge.
   task automatic issue(input logic [3:0] n, input logic [15:0] f, input logic [31:0] res,
                        input string tag, input bit expect_accept);
      exp_t e;
      bus.start_i     = 1'b1;
      bus.ynguyen_i   = n;
      bus.ythapphan_i = f;
      if (expect_accept) begin
         e.res        = res;
         e.accept_cyc = cyc + 1;
         e.lat        = 18 + 17 * $countones(f);
         e.n          = n;
         e.f          = f;
         e.tag        = tag;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.start_i     = 1'b0;
      bus.ynguyen_i   = 4'($urandom);
      bus.ythapphan_i = 16'($urandom);
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int c;
      c = 0;
      while (done_seen < target && c < budget) begin
         @(posedge clk);
         c++;
      end
      check({tag, "_done_in_budget"}, done_seen >= target, done_seen, target);
   endtask

   // Called at a negedge; returns at the negedge of the idle cycle after DONE,
   // so consecutive calls run back to back.
   task automatic run_op(input logic [3:0] n, input logic [15:0] f, input logic [31:0] res,
                         input string tag);
      int target;
      target = done_seen + 1;
      issue(n, f, res, tag, 1'b1);
      check({tag, "_busy_rise"}, bus.busy_o == 1'b1, bus.busy_o, 1);
      wait_done(target, 400, tag);
      @(negedge clk);
      check({tag, "_busy_fall"}, bus.busy_o == 1'b0, bus.busy_o, 0);
   endtask

   initial begin : stim
      int          base;
      logic [3:0]  rn;
      logic [15:0] rf;

      bus.start_i     = 1'b0;
      bus.ynguyen_i   = '0;
      bus.ythapphan_i = '0;
      rst_n           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   bus.busy_o == 1'b0,      bus.busy_o,   0);
      check("reset_done",   bus.done_o == 1'b0,      bus.done_o,   0);
      check("reset_result", bus.result_o == 32'h0,   bus.result_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, back to back.
      run_op(4'd0,  16'h0000, 32'h0001_0000, "n0_f0000");
      run_op(4'd4,  16'h0000, 32'h0010_0000, "n4_f0000");
      run_op(4'd0,  16'h8000, 32'h0001_6A0A, "n0_f8000");
      run_op(4'd2,  16'h4000, 32'h0004_C1C0, "n2_f4000");
      run_op(4'd1,  16'hC000, 32'h0003_5D14, "n1_fC000");
      run_op(4'd15, 16'hFFFF, model_exp(4'd15, 16'hFFFF), "n15_fFFFF");
      check("n15_fFFFF_no_wrap", bus.result_o[31] == 1'b1, bus.result_o, 32'h8000_0000);

      // A second start while busy must be ignored.
      base = done_seen;
      issue(4'd5, 16'h0000, 32'h0020_0000, "busy_first", 1'b1);
      repeat (4) @(negedge clk);
      issue(4'd9, 16'hFFFF, 32'h0, "busy_second", 1'b0);
      wait_done(base + 1, 400, "busy_first");
      repeat (40) @(negedge clk);
      check("busy_single_done", done_seen == base + 1, done_seen, base + 1);

      // Reset in the middle of a multiply.
      issue(4'd3, 16'h4000, 32'h0, "aborted", 1'b0);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midmul_reset_busy",   bus.busy_o == 1'b0,    bus.busy_o,   0);
      check("midmul_reset_done",   bus.done_o == 1'b0,    bus.done_o,   0);
      check("midmul_reset_result", bus.result_o == 32'h0, bus.result_o, 0);
      base = done_seen;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("midmul_no_done",    done_seen == base,   done_seen,  base);
      check("midmul_idle_after", bus.busy_o == 1'b0,  bus.busy_o, 0);
      run_op(4'd1, 16'h0000, 32'h0002_0000, "post_reset_n1_f0000");

      // Random exponents against both references.
      for (int i = 0; i < 6; i++) begin
         rn = 4'($urandom_range(0, 15));
         rf = 16'($urandom);
         run_op(rn, rf, model_exp(rn, rf), $sformatf("rand%0d", i));
      end

      check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
